// File: rtl/peri_uart_tx.sv
// peri_uart_tx: Wishbone-attached UART transmitter.
// Bytes written to DATA are queued in a TX FIFO and sent 8N1, LSB first.
// Registers: 0 DATA (W), 1 STATUS (R, read clears overflow), 2 CTRL (enable / flush).
module peri_uart_tx #(
  parameter int AddrSz       = 4,
  parameter int DataSz       = 8,
  parameter int FifoDepth    = 16,
  parameter int TicksPerBaud = 104
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_we_i,
  input  logic [AddrSz-1:0] wb_adr_i,
  input  logic [DataSz-1:0] wb_dat_i,
  input  logic              wb_stb_i,
  output logic [DataSz-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              uart_tx_o
);

  localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int LvlW  = $clog2(FifoDepth + 1);
  localparam int BaudW = $clog2(TicksPerBaud);

  localparam logic [LvlW-1:0]   LvlFull  = LvlW'(FifoDepth);
  localparam logic [BaudW-1:0]  BaudLast = BaudW'(TicksPerBaud - 1);
  localparam logic [AddrSz-1:0] AdrData  = AddrSz'(0);
  localparam logic [AddrSz-1:0] AdrStat  = AddrSz'(1);
  localparam logic [AddrSz-1:0] AdrCtrl  = AddrSz'(2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus-side registers
  logic              r_ack;
  logic [DataSz-1:0] r_dat;
  logic              r_en;
  logic              r_ovf;

  // FIFO
  logic [7:0]        r_mem [FifoDepth];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [LvlW-1:0]   r_level;

  // Transmitter
  state_t            r_state;
  logic [BaudW-1:0]  r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;

  logic              w_req;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_flush;
  logic              w_ctrl_wr;
  logic              w_stat_rd;
  logic              w_ovf_set;
  logic              w_baud_done;
  logic [DataSz-1:0] w_rdata;
  state_t            w_state_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_tx_nxt;

  // A new transaction is one strobe cycle not already being acked.
  assign w_req       = wb_stb_i & ~r_ack;
  assign w_push_req  = w_req & wb_we_i & (wb_adr_i == AdrData);
  assign w_ctrl_wr   = w_req & wb_we_i & (wb_adr_i == AdrCtrl);
  assign w_flush     = w_ctrl_wr & wb_dat_i[1];
  assign w_stat_rd   = w_req & ~wb_we_i & (wb_adr_i == AdrStat);
  assign w_full      = (r_level == LvlFull);
  assign w_empty     = (r_level == '0);
  // When full, a push is still accepted if the transmitter frees a slot this cycle.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_ovf_set   = w_push_req & w_full & ~w_pop;
  assign w_baud_done = (r_baud == BaudLast);

  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat;
  assign uart_tx_o = r_tx;

  // Read-data mux; unmapped addresses and DATA read as zero.
  always_comb begin
    w_rdata = '0;
    if (wb_adr_i == AdrStat) begin
      w_rdata = {r_ovf, (r_state != S_IDLE), w_full, 5'(r_level)};
    end else if (wb_adr_i == AdrCtrl) begin
      w_rdata = {7'd0, r_en};
    end
  end

  // Bus handshake, read data capture, control register and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_en  <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~wb_we_i) ? w_rdata : '0;
      if (w_ctrl_wr) r_en <= wb_dat_i[0];
      // A new overflow in the same cycle as a STATUS read stays visible.
      r_ovf <= w_ovf_set | (r_ovf & ~w_stat_rd);
    end
  end

  // FIFO pointers and level counter; flush takes priority over push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage, data only.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wb_dat_i[7:0];
  end

  // TX next-state, pop request and next line level.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_en && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (r_en && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_pop) w_shift_nxt = r_mem[r_rptr];
    // The line is registered, so it is derived from the state being entered.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // TX state, baud/bit counters and registered serial line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      if (r_state == S_IDLE || w_baud_done) r_baud <= '0;
      else                                  r_baud <= r_baud + 1'b1;
      if (r_state != S_DATA)   r_bit <= '0;
      else if (w_baud_done)    r_bit <= r_bit + 1'b1;
    end
  end

  // Shift register, data only.
  always_ff @(posedge clk_i) begin
    r_shift <= w_shift_nxt;
  end

endmodule

// File: tb/tb_peri_uart_tx.sv
// tb_peri_uart_tx: scoreboard bench for peri_uart_tx (TicksPerBaud=4, FifoDepth=16).
// Bus reads and transmitted bytes are queued as expectations; independent monitors
// on the ack and on the serial line pop and compare.
module tb_peri_uart_tx;

  localparam int T = 4;

  logic       clk   = 1'b0;
  logic       rst_i = 1'b1;
  logic       we    = 1'b0;
  logic       stb   = 1'b0;
  logic [3:0] adr   = '0;
  logic [7:0] dat   = '0;
  logic [7:0] dat_o;
  logic       ack;
  logic       tx;

  peri_uart_tx #(
    .AddrSz(4), .DataSz(8), .FifoDepth(16), .TicksPerBaud(T)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack), .uart_tx_o(tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rd;
    logic [3:0] adr;
    logic [7:0] exp;
  } bus_exp_t;

  bus_exp_t   bus_q [$];
  logic [7:0] tx_q  [$];
  int         starts[$];
  bus_exp_t   mon_e;
  int         cyc       = 0;
  int         rx_cnt    = -1;
  int         rx_frames = 0;
  logic [7:0] rx_sh     = '0;
  logic       prev_tx   = 1'b1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Bus monitor: every ack consumes one expectation; reads are compared.
  always @(negedge clk) begin
    if (ack) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=ack required=no_ack");
      end else begin
        mon_e = bus_q.pop_front();
        if (mon_e.rd) check($sformatf("rdata_adr%0d", mon_e.adr), dat_o, mon_e.exp);
      end
    end
  end

  // Serial monitor: mid-bit sampling, 8N1 LSB first.
  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      rx_cnt = -1;
    end else if (rx_cnt < 0) begin
      if (prev_tx && !tx) begin
        rx_cnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 2) begin
        check("start_bit", tx, 0);
      end else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) begin
        rx_sh = {tx, rx_sh[7:1]};
      end else if (rx_cnt == 38) begin
        check("stop_bit", tx, 1);
        rx_frames++;
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=0x%0h required=none", rx_sh);
        end else begin
          check("rx_byte", rx_sh, tx_q.pop_front());
        end
        rx_cnt = -1;
      end
    end
    prev_tx = tx;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic bus(input logic w, input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp);
    bus_q.push_back({~w, a, exp});
    stb = 1'b1;
    we  = w;
    adr = a;
    dat = d;
    step(1);
    check($sformatf("ack_adr%0d", a), ack, 1);
    stb = 1'b0;
    we  = 1'b0;
    step(1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 8'h00);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    bus(1'b0, a, 8'h00, exp);
  endtask

  task automatic send(input logic [7:0] d);
    tx_q.push_back(d);
    wr(4'd0, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles
    rst_i = 1'b1;
    step(2);
    rst_i = 1'b0;
    check("reset_tx", tx, 1);
    check("reset_ack", ack, 0);
    check("reset_dat", dat_o, 0);
    rd(4'd1, 8'h00);
    rd(4'd2, 8'h01);
    rd(4'd0, 8'h00);

    // Single byte
    send(8'h55);
    check("tx_fall_latency", tx, 0);
    rd(4'd1, 8'h40);
    step(45);
    check("frames_single", rx_frames, 1);
    rd(4'd1, 8'h00);

    // Back-to-back frames
    starts.delete();
    send(8'hA5);
    send(8'h01);
    send(8'hFF);
    rd(4'd1, 8'h42);
    step(130);
    check("frames_b2b", rx_frames, 4);
    check("b2b_starts", starts.size(), 3);
    if (starts.size() >= 3) begin
      check("b2b_gap1", starts[1] - starts[0], 10 * T);
      check("b2b_gap2", starts[2] - starts[1], 10 * T);
    end

    // Overflow with transmitter disabled
    wr(4'd2, 8'h00);
    rd(4'd2, 8'h00);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) send(8'(8'h30 + i));
      else        wr(4'd0, 8'(8'h30 + i));
    end
    rd(4'd1, 8'hB0);
    rd(4'd1, 8'h30);
    wr(4'd2, 8'h01);
    step(700);
    check("frames_overflow", rx_frames, 20);
    check("overflow_drained", tx_q.size(), 0);
    rd(4'd1, 8'h00);

    // Reset in the middle of data bit 3
    send(8'hF0);
    step(17);
    check("pre_reset_bit3", tx, 0);
    rst_i = 1'b1;
    step(1);
    check("midframe_reset_tx", tx, 1);
    check("midframe_reset_ack", ack, 0);
    rst_i = 1'b0;
    tx_q.delete();
    rd(4'd1, 8'h00);
    rd(4'd2, 8'h01);

    // Flush with queued bytes, then unmapped address
    send(8'h11);
    for (int i = 0; i < 5; i++) wr(4'd0, 8'(8'h21 + i));
    wr(4'd2, 8'h02);
    rd(4'd1, 8'h40);
    rd(4'd2, 8'h00);
    step(50);
    rd(4'd1, 8'h00);
    wr(4'd2, 8'h01);
    step(50);
    check("frames_flush", rx_frames, 21);
    rd(4'd7, 8'h00);
    wr(4'd7, 8'hFE);
    rd(4'd2, 8'h01);

    check("bus_q_empty", bus_q.size(), 0);
    check("tx_q_empty", tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
